// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers.
//
// Sits beside the EX stage. A mult/multu/div/divu accepted while idle computes
// its 64-bit result at once, parks it in a pending register, and holds busy
// for MULT_CYCLES or DIV_CYCLES before committing it to HI/LO. That matches
// the timing of an iterative unit while keeping the datapath simple.
// mthi/mtlo write HI/LO on the next edge and do not raise busy.
//
// Optional build macro: MDU_FLUSH_EN adds a `flush` input that squashes the
// in-flight operation without touching HI/LO.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_ok;   // pending result may commit (false after divide by zero)

    logic             flush_req;
    logic             is_signed;
    logic             is_mul;
    logic             is_div;
    logic             accept;

    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] mul_p;

    logic [31:0] div_a_mag;
    logic [31:0] div_b_mag;
    logic [31:0] div_b_safe;
    logic [31:0] div_uq;
    logic [31:0] div_ur;
    logic [31:0] div_q;
    logic [31:0] div_r;

    logic [31:0] res_hi;
    logic [31:0] res_lo;

`ifdef MDU_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Even opcodes (mult/div) are the signed forms, odd ones unsigned.
    assign is_signed = ~op[0];
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign accept    = start && (is_mul || is_div) && !flush_req;
    assign busy      = (cnt != '0);

    // Result datapath: one 33x33 signed multiplier covers both mult forms; the
    // divider works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        mul_a      = '0;
        mul_b      = '0;
        mul_p      = '0;
        div_a_mag  = A;
        div_b_mag  = B;
        div_b_safe = 32'd1;
        div_uq     = '0;
        div_ur     = '0;
        div_q      = '0;
        div_r      = '0;
        res_hi     = '0;
        res_lo     = '0;

        mul_a = {is_signed & A[31], A};
        mul_b = {is_signed & B[31], B};
        mul_p = mul_a * mul_b;

        if (is_signed && A[31]) div_a_mag = -A;
        if (is_signed && B[31]) div_b_mag = -B;
        // Divide by zero never commits; feed a harmless divisor instead.
        div_b_safe = (div_b_mag == '0) ? 32'd1 : div_b_mag;
        div_uq     = div_a_mag / div_b_safe;
        div_ur     = div_a_mag % div_b_safe;
        // Quotient truncates toward zero; remainder follows the dividend.
        div_q = (is_signed && (A[31] ^ B[31])) ? -div_uq : div_uq;
        div_r = (is_signed && A[31])           ? -div_ur : div_ur;

        if (is_mul) begin
            res_hi = mul_p[63:32];
            res_lo = mul_p[31:0];
        end else begin
            res_hi = div_r;
            res_lo = div_q;
        end
    end

    // Sequencer: accept a new op when idle, count it down, commit on 1->0.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the pending result is reset along with HI/LO because it is a
        // handful of flops, not a RAM, and an abort must leave no stale data.
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else if (cnt == '0) begin
            // NOTE: non-blocking assignments throughout so every flop samples
            // pre-edge values regardless of statement order.
            if (accept) begin
                cnt     <= is_mul ? MULT_LAT : DIV_LAT;
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_ok <= !(is_div && (B == '0));
            end else if (!start) begin
                if (op == OP_MTHI) HI <= A;
                if (op == OP_MTLO) LO <= A;
            end
        end else if (flush_req) begin
            cnt     <= '0;
            pend_ok <= 1'b0;
        end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1) && pend_ok) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed, table-driven bench for md_unit.
// Build with MDU_FLUSH_EN defined to also exercise the flush port.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MDU_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_FLUSH_EN
        .flush (flush),
`endif
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        start;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, then count busy cycles (bounded) until idle.
    task automatic run_op(input logic st, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        start = st; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'd7; A = '0; B = '0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic add(input string nm, input logic st, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] hi, input logic [31:0] lo);
        vec_t v;
        v.name = nm; v.start = st; v.op = o; v.a = a; v.b = b;
        v.lat = lat; v.hi = hi; v.lo = lo;
        vecs.push_back(v);
    endtask

    initial begin
        int n;

        // Results accumulate: each expected HI/LO includes earlier effects.
        add("mult_m2x3",   1, 0, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
        add("multu_m2x3",  1, 1, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA);
        add("div_m7d2",    1, 2, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add("divu_7d2",    1, 3, 32'd7,        32'd2,        10, 32'h00000001, 32'h00000003);
        add("mthi",        0, 4, 32'h12345678, 32'd0,        0,  32'h12345678, 32'h00000003);
        add("mtlo",        0, 5, 32'h9ABCDEF0, 32'd0,        0,  32'h12345678, 32'h9ABCDEF0);
        add("div_by0",     1, 2, 32'd5,        32'd0,        10, 32'h12345678, 32'h9ABCDEF0);
        add("divu_by0",    1, 3, 32'hFFFFFFFF, 32'd0,        10, 32'h12345678, 32'h9ABCDEF0);
        add("div_ovf",     1, 2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        add("mult_minsq",  1, 0, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000);
        add("multu_max",   1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        add("div_7dm2",    1, 2, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        add("start_op6",   1, 6, 32'hDEADBEEF, 32'd1,        0,  32'h00000001, 32'hFFFFFFFD);
        add("start_mthi",  1, 4, 32'hDEADBEEF, 32'd1,        0,  32'h00000001, 32'hFFFFFFFD);
        add("nostart_op7", 0, 7, 32'hDEADBEEF, 32'd1,        0,  32'h00000001, 32'hFFFFFFFD);
        add("divu_max16",  1, 3, 32'hFFFFFFFF, 32'd16,       10, 32'h0000000F, 32'h0FFFFFFF);

        // Reset held low for 3 cycles.
        reset = 1'b0; start = 1'b0; op = 3'd7; A = '0; B = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].start, vecs[i].op, vecs[i].a, vecs[i].b, n);
            check({vecs[i].name, "_lat"}, 32'(n), 32'(vecs[i].lat));
            check({vecs[i].name, "_hi"}, HI, vecs[i].hi);
            check({vecs[i].name, "_lo"}, LO, vecs[i].lo);
        end

        // A mult must ignore a new div start in its 2nd cycle and an mthi in its 3rd.
        start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd7;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) n++;
            start = (i == 1);
            op    = (i == 1) ? 3'd2 : (i == 2) ? 3'd4 : 3'd7;
            A     = (i == 1) ? 32'd100 : (i == 2) ? 32'h0000CAFE : 32'd0;
            B     = (i == 1) ? 32'd3 : 32'd0;
            @(negedge clk);
        end
        check("ignore_lat", 32'(n), 32'd5);
        check("ignore_hi", HI, 32'd0);
        check("ignore_lo", LO, 32'd35);

`ifdef MDU_FLUSH_EN
        // Flush in the 4th busy cycle of a div: busy drops next edge, HI/LO keep.
        start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
        check("flush_hi", HI, 32'd0);
        check("flush_lo", LO, 32'd35);
        // Flush together with start while idle: start is dropped.
        flush = 1'b1; start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd2;
        @(negedge clk);
        flush = 1'b0; start = 1'b0; op = 3'd7;
        check("flush_start_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        check("flush_start_lo", LO, 32'd35);
`endif

        // Async reset in the middle of a div clears everything without an edge.
        run_op(0, 4, 32'hA5A5A5A5, 32'd0, n);
        start = 1'b1; op = 3'd2; A = 32'd40; B = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd7;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("post_abort_hi", HI, 32'd0);
        check("post_abort_lo", LO, 32'd0);

        // Normal operation resumes after the abort.
        run_op(1, 0, 32'd6, 32'hFFFFFFF9, n);
        check("resume_lat", 32'(n), 32'd5);
        check("resume_hi", HI, 32'hFFFFFFFF);
        check("resume_lo", LO, 32'hFFFFFFD6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
